hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard controller for the five-stage CPU. It decodes the instruction in IF/ID and keeps its own shadow record of the destination registers in EX, MEM and WB. From these it produces the PC/IFID stall, IDEX bubble and flush strobes, plus registered forwarding selects for the EX stage. It sits next to the control decoder and drives the enables of every pipeline register.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- PR_IFID_Inst  in  32  instruction currently in ID.
- PR_IFID_Valid  in  1  the ID instruction is real, not a bubble.
- Branch_Taken  in  1  a BEQ in EX resolved taken this cycle.
- Ext_Stall  in  1  memory wait: freeze the whole pipeline.
- Stall_PC  out  1  hold the PC.
- Stall_IFID  out  1  hold IF/ID.
- Bubble_IDEX  out  1  load a NOP into ID/EX.
- Flush_IFID  out  1  invalidate IF/ID.
- Fwd_A  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
- Fwd_B  out  2  EX operand B select, same encoding as Fwd_A.
- Stall_Count  out  CNT_W  number of cycles in which Bubble_IDEX was due to a data hazard.

## Operation
- Decode of the ID instruction:
  - Opcode 000000 (ALUOP): dest = rd. Sources = rs and rt. When func[5:2]==0 (shift), the only source is rt.
  - LW (100011): dest = rt, source = rs.
  - SW (101011): sources rs and rt, no dest.
  - BEQ (000100): sources rs and rt, no dest.
  - All other opcodes: no sources, no dest.
  - A dest equal to 0 counts as no write.
- Shadow pipeline: three entries, EX, MEM and WB, each holding {valid, dest[4:0], is_load}.
  - On a non-stalled cycle: ID→EX, EX→MEM, MEM→WB.
  - The EX entry is loaded invalid when Bubble_IDEX is high or PR_IFID_Valid is low.
- Hazard rule (FORWARDING_EN defined): a load-use hazard exists when a valid EX entry has is_load=1 and its dest matches any ID source.
  - On a hazard: Stall_PC = Stall_IFID = Bubble_IDEX = 1.
- Forwarding: computed in ID and registered into Fwd_A/Fwd_B as the instruction advances into EX.
  - Per operand: a match on the EX entry gives 01, else a match on the MEM entry gives 10, else 00. The youngest producer wins.
  - A bubble loads 00.
- Branch:
  - When Branch_Taken=1, Flush_IFID = Bubble_IDEX = 1.
  - The hazard stall is suppressed: Stall_PC = Stall_IFID = 0 so the PC loads the target.
  - Flush takes priority over the load-use stall.
- Ext_Stall=1 has priority over everything:
  - Stall_PC = Stall_IFID = 1.
  - Bubble_IDEX = Flush_IFID = 0.
  - Shadow pipeline, Fwd and counter hold.
  - Branch_Taken is ignored; EX is frozen, so the branch re-presents.
- Stall_Count increments by 1 on every cycle with a hazard-induced bubble (not flushes, not Ext_Stall). It saturates at all-ones.
- Reset values:
  - Every output is 0.
  - Shadow entries are invalid and Fwd is 00.
  - Stall_Count is 0.

## Timing
- Stall, bubble and flush outputs are combinational from PR_IFID_Inst and registered state, in the same cycle.
- Fwd_A/Fwd_B are registered: valid in the cycle the instruction is in EX.
- Load-use sequence:
  - Cycle N: LW in EX, dependent in ID. Stall and bubble asserted.
  - Cycle N+1: LW in MEM, bubble in EX, no hazard.
  - Cycle N+2: dependent in EX with Fwd=10.
  - Net penalty is exactly 1 cycle.
- Writes from WB reach the regfile in the first half-cycle, so a WB match needs neither a stall nor forwarding.
- If reset is asserted mid-stall, all outputs are 0 the next cycle and the shadow is cleared.

## Configuration
- FORWARDING_EN defined: forwarding as above; only load-use hazards stall.
- FORWARDING_EN undefined:
  - Fwd_A/Fwd_B are tied to 00.
  - A stall plus bubble occurs whenever any ID source matches a valid EX or MEM dest, whether ALU or load.
  - Maximum penalty is 2 cycles.
  - Branch and Ext_Stall rules are unchanged.

## Test plan
- LW $2,0($1) then ADD $3,$2,$4 (FORWARDING_EN) -> one cycle with Stall_PC/Stall_IFID/Bubble_IDEX=1; ADD in EX has Fwd_A=10; Stall_Count=1.
- ADD $5,$1,$1 then SUB $6,$5,$5 -> no stall; SUB in EX has Fwd_A=Fwd_B=01. Same pair with FORWARDING_EN undefined -> 2 stall cycles, Fwd=00.
- ADD $0,$1,$1 then ADD $2,$0,$0 -> no stall, Fwd=00, because register 0 is never a hazard.
- Load-use hazard in ID and Branch_Taken=1 in the same cycle -> Flush_IFID=Bubble_IDEX=1, Stall_PC=0; Stall_Count unchanged.
- Ext_Stall=1 for 3 cycles during a load-use hazard -> stall outputs held, Bubble_IDEX=0, Fwd and shadow unchanged; after release, exactly one bubble.
- Stall_Count at all-ones plus another hazard -> count stays all-ones; reset -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: load-use/data hazard stall, branch flush and EX forwarding control.
// Ports: clock/reset (sync, active-high); PR_IFID_Inst/PR_IFID_Valid = ID instruction;
// Branch_Taken = taken BEQ in EX; Ext_Stall = freeze all; Stall_PC/Stall_IFID/Bubble_IDEX/
// Flush_IFID = pipeline register controls; Fwd_A/Fwd_B = registered EX operand selects;
// Stall_Count = saturating count of data-hazard bubbles.
// Macro FORWARDING_EN: defined -> forwarding, only load-use stalls; undefined -> stall on any EX/MEM match.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      PR_IFID_Inst,
    input  logic             PR_IFID_Valid,
    input  logic             Branch_Taken,
    input  logic             Ext_Stall,
    output logic             Stall_PC,
    output logic             Stall_IFID,
    output logic             Bubble_IDEX,
    output logic             Flush_IFID,
    output logic [1:0]       Fwd_A,
    output logic [1:0]       Fwd_B,
    output logic [CNT_W-1:0] Stall_Count
);
    logic [5:0] op;
    logic [4:0] rs, rt, rd, id_dest;
    logic is_alu, is_lw, is_sw, is_beq, is_shift;
    logic use_a, use_b, id_wr;
    logic a_ex, a_mem, b_ex, b_mem, hazard;
    logic ex_v_q, mem_v_q;
    logic [4:0] ex_dest_q, mem_dest_q;
    logic [CNT_W-1:0] cnt_q;

    assign op       = PR_IFID_Inst[31:26];
    assign rs       = PR_IFID_Inst[25:21];
    assign rt       = PR_IFID_Inst[20:16];
    assign rd       = PR_IFID_Inst[15:11];
    assign is_alu   = op == 6'b000000;
    assign is_lw    = op == 6'b100011;
    assign is_sw    = op == 6'b101011;
    assign is_beq   = op == 6'b000100;
    assign is_shift = PR_IFID_Inst[5:2] == 4'd0;

    // Shifts read only rt, which is carried on operand B.
    assign use_a   = PR_IFID_Valid & ((is_alu & ~is_shift) | is_lw | is_sw | is_beq);
    assign use_b   = PR_IFID_Valid & (is_alu | is_sw | is_beq);
    assign id_dest = is_alu ? rd : rt;
    assign id_wr   = PR_IFID_Valid & (is_alu | is_lw) & (id_dest != 5'd0);

    // WB producers write the regfile in the first half-cycle, so only EX and MEM are tracked.
    assign a_ex  = use_a & ex_v_q  & (ex_dest_q  == rs);
    assign b_ex  = use_b & ex_v_q  & (ex_dest_q  == rt);
    assign a_mem = use_a & mem_v_q & (mem_dest_q == rs);
    assign b_mem = use_b & mem_v_q & (mem_dest_q == rt);

`ifdef FORWARDING_EN
    logic ex_ld_q;
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
    assign hazard  = ex_ld_q & (a_ex | b_ex);
    assign fwd_a_d = a_ex ? 2'b01 : a_mem ? 2'b10 : 2'b00;
    assign fwd_b_d = b_ex ? 2'b01 : b_mem ? 2'b10 : 2'b00;
    assign Fwd_A   = fwd_a_q;
    assign Fwd_B   = fwd_b_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_ld_q <= 1'b0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (!Ext_Stall) begin
            ex_ld_q <= is_lw;
            fwd_a_q <= Bubble_IDEX ? 2'b00 : fwd_a_d;
            fwd_b_q <= Bubble_IDEX ? 2'b00 : fwd_b_d;
        end
    end
`else
    assign hazard = a_ex | b_ex | a_mem | b_mem;
    assign Fwd_A  = 2'b00;
    assign Fwd_B  = 2'b00;
`endif

    // Ext_Stall freezes everything; a taken branch overrides the hazard stall so the PC can redirect.
    assign Stall_PC    = Ext_Stall | (~Branch_Taken & hazard);
    assign Stall_IFID  = Stall_PC;
    assign Bubble_IDEX = ~Ext_Stall & (Branch_Taken | hazard);
    assign Flush_IFID  = ~Ext_Stall & Branch_Taken;
    assign Stall_Count = cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_v_q     <= 1'b0;
            ex_dest_q  <= 5'd0;
            mem_v_q    <= 1'b0;
            mem_dest_q <= 5'd0;
            cnt_q      <= '0;
        end else if (!Ext_Stall) begin
            ex_v_q     <= id_wr & ~Bubble_IDEX;
            ex_dest_q  <= id_dest;
            mem_v_q    <= ex_v_q;
            mem_dest_q <= ex_dest_q;
            if (hazard && !Branch_Taken && !(&cnt_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table-driven directed check of hazard_controller (CNT_W=3).
module tb_hazard_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] inst = 32'd0;
    logic vld = 1'b1, br = 1'b0, ext = 1'b0;
    logic stall_pc, stall_ifid, bubble, flush;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] cnt;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(3)) dut (
        .clock(clk), .reset(reset), .PR_IFID_Inst(inst), .PR_IFID_Valid(vld),
        .Branch_Taken(br), .Ext_Stall(ext), .Stall_PC(stall_pc), .Stall_IFID(stall_ifid),
        .Bubble_IDEX(bubble), .Flush_IFID(flush), .Fwd_A(fwd_a), .Fwd_B(fwd_b),
        .Stall_Count(cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic        vld, br, ext;
        logic [10:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] lw(logic [4:0] rs, logic [4:0] rt);
        return {6'h23, rs, rt, 16'd0};
    endfunction
    // Expected {Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID, Fwd_A, Fwd_B, Stall_Count}.
    function automatic logic [10:0] e(logic s, logic b, logic f, logic [1:0] fa, logic [1:0] fb, logic [2:0] c);
        return {s, s, b, f, fa, fb, c};
    endfunction
    task automatic add(logic [31:0] i, logic v, logic bt, logic x, logic [10:0] ex);
        vec_t t;
        t.inst = i; t.vld = v; t.br = bt; t.ext = x; t.exp = ex;
        tbl.push_back(t);
    endtask
    task automatic drive(logic [31:0] i, logic v, logic bt, logic x);
        @(negedge clk);
        inst = i; vld = v; br = bt; ext = x;
        #1;
    endtask
    task automatic check(string name, logic [10:0] exp);
        logic [10:0] got;
        got = {stall_pc, stall_ifid, bubble, flush, fwd_a, fwd_b, cnt};
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b (spc,sif,bub,fl,fa,fb,cnt)", name, got, exp);
        end
    endtask

    logic [31:0] nop, lw2, add3, add5, sub6, add0, add2;

    initial begin
        nop  = 32'd0;
        lw2  = lw(5'd1, 5'd2);
        add3 = rtype(5'd2, 5'd4, 5'd3, 6'h20);
        add5 = rtype(5'd1, 5'd1, 5'd5, 6'h20);
        sub6 = rtype(5'd5, 5'd5, 5'd6, 6'h22);
        add0 = rtype(5'd1, 5'd1, 5'd0, 6'h20);
        add2 = rtype(5'd0, 5'd0, 5'd2, 6'h20);
`ifdef FORWARDING_EN
        // load-use: one bubble, ADD in EX takes operand A from MEM/WB
        add(lw2,  1, 0, 0, e(0, 0, 0, 0, 0, 0));
        add(add3, 1, 0, 0, e(1, 1, 0, 0, 0, 0));
        add(add3, 1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 2, 0, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        // ALU-ALU: no stall, both operands from EX/MEM; Fwd holds across Ext_Stall
        add(add5, 1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(sub6, 1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(nop,  1, 0, 1, e(1, 0, 0, 1, 1, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 1, 1, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        // register 0 never hazards
        add(add0, 1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(add2, 1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        // load-use and taken branch together: flush wins, count unchanged
        add(lw2,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(add3, 1, 1, 0, e(0, 1, 1, 0, 0, 1));
        add(nop,  0, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        // Ext_Stall during load-use (branch ignored), then exactly one bubble
        add(lw2,  1, 0, 0, e(0, 0, 0, 0, 0, 1));
        add(add3, 1, 0, 1, e(1, 0, 0, 0, 0, 1));
        add(add3, 1, 1, 1, e(1, 0, 0, 0, 0, 1));
        add(add3, 1, 0, 1, e(1, 0, 0, 0, 0, 1));
        add(add3, 1, 0, 0, e(1, 1, 0, 0, 0, 1));
        add(add3, 1, 0, 0, e(0, 0, 0, 0, 0, 2));
        add(nop,  1, 0, 0, e(0, 0, 0, 2, 0, 2));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 2));
`else
        // load-use: two bubbles, no forwarding
        add(lw2,  1, 0, 0, e(0, 0, 0, 0, 0, 0));
        add(add3, 1, 0, 0, e(1, 1, 0, 0, 0, 0));
        add(add3, 1, 0, 0, e(1, 1, 0, 0, 0, 1));
        add(add3, 1, 0, 0, e(0, 0, 0, 0, 0, 2));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 2));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 2));
        // ALU-ALU: two stall cycles, Fwd stays 00
        add(add5, 1, 0, 0, e(0, 0, 0, 0, 0, 2));
        add(sub6, 1, 0, 0, e(1, 1, 0, 0, 0, 2));
        add(sub6, 1, 0, 0, e(1, 1, 0, 0, 0, 3));
        add(sub6, 1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(nop,  1, 0, 1, e(1, 0, 0, 0, 0, 4));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        // register 0 never hazards
        add(add0, 1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(add2, 1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        // hazard and taken branch together: flush wins, count unchanged
        add(lw2,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(add3, 1, 1, 0, e(0, 1, 1, 0, 0, 4));
        add(nop,  0, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        // Ext_Stall during hazard (branch ignored), then the normal two bubbles
        add(lw2,  1, 0, 0, e(0, 0, 0, 0, 0, 4));
        add(add3, 1, 0, 1, e(1, 0, 0, 0, 0, 4));
        add(add3, 1, 1, 1, e(1, 0, 0, 0, 0, 4));
        add(add3, 1, 0, 1, e(1, 0, 0, 0, 0, 4));
        add(add3, 1, 0, 0, e(1, 1, 0, 0, 0, 4));
        add(add3, 1, 0, 0, e(1, 1, 0, 0, 0, 5));
        add(add3, 1, 0, 0, e(0, 0, 0, 0, 0, 6));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 6));
        add(nop,  1, 0, 0, e(0, 0, 0, 0, 0, 6));
`endif
        repeat (2) @(posedge clk);
        drive(nop, 1, 0, 0);
        reset = 1'b0;
        check("reset_state", e(0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].inst, tbl[i].vld, tbl[i].br, tbl[i].ext);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
        // drive the counter into saturation
        for (int k = 0; k < 8; k++) begin
            drive(lw2, 1, 0, 0);
            drive(add3, 1, 0, 0);
            drive(add3, 1, 0, 0);
            repeat (3) drive(nop, 1, 0, 0);
        end
        check("sat_reached", e(0, 0, 0, 0, 0, 7));
        drive(lw2, 1, 0, 0);
        drive(add3, 1, 0, 0);
        check("sat_hazard", e(1, 1, 0, 0, 0, 7));
        drive(nop, 1, 0, 0);
        check("sat_hold", e(0, 0, 0, 0, 0, 7));
        repeat (2) drive(nop, 1, 0, 0);
        // reset in the middle of a load-use stall
        drive(lw2, 1, 0, 0);
        drive(add3, 1, 0, 0);
        check("pre_reset_stall", e(1, 1, 0, 0, 0, 7));
        reset = 1'b1;
        drive(add3, 1, 0, 0);
        reset = 1'b0;
        check("reset_mid_stall", e(0, 0, 0, 0, 0, 0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
